// File: rtl/rom_pixel_streamer.sv
// Raster-scans a 1-cycle-latency synchronous ROM and presents its pixels as a
// valid/ready stream tagged with x/y coordinates and sof/eol/eof markers.
module rom_pixel_streamer #(
  parameter int WIDTH   = 256,
  parameter int HEIGHT  = 256,
  parameter int PIXEL_W = 8,
  parameter int ADDR_W  = 16,
  parameter int X_W     = 8,
  parameter int Y_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [PIXEL_W-1:0] rom_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIXEL_W-1:0] m_data,
  output logic [X_W-1:0]     m_x,
  output logic [Y_W-1:0]     m_y,
  output logic               m_sof,
  output logic               m_eol,
  output logic               m_eof
);

  localparam int META_W = X_W + Y_W + 3;
  localparam int ENT_W  = PIXEL_W + META_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [X_W-1:0]    LAST_X    = X_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                inflight_q, inflight_d;
  logic [META_W-1:0]   pend_q, pend_d;
  logic [ENT_W-1:0]    fifo_q [2];
  logic [ENT_W-1:0]    fifo_d [2];
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                done_q, done_d;

  logic [ENT_W-1:0]    head;
  logic                pop;
  logic                iss_sof, iss_eol, iss_eof;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x_d        = x_q;
    y_d        = y_q;
    pend_d     = pend_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    done_d     = 1'b0;

    head    = fifo_q[rd_ptr_q];
    m_valid = (count_q != 2'd0);
    pop     = m_valid & m_ready;

    iss_sof = (x_q == '0) && (y_q == '0);
    iss_eol = (x_q == LAST_X);
    iss_eof = (addr_q == LAST_ADDR);

    // Written as count + inflight < 2 + pop so the sum never goes negative.
    rom_en = (state_q == S_RUN) &&
             (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    inflight_d = rom_en;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_RUN: begin
        if (rom_en && iss_eof) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (pop && head[0]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rom_en) begin
      addr_d = addr_q + 1'b1;
      pend_d = {x_q, y_q, iss_sof, iss_eol, iss_eof};
      if (iss_eol) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    if (inflight_q) begin
      fifo_d[wr_ptr_q] = {rom_data, pend_q};
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    case ({inflight_q, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      pend_q     <= '0;
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      inflight_q <= inflight_d;
      pend_q     <= pend_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rom_addr = addr_q;
  assign {m_data, m_x, m_y, m_sof, m_eol, m_eof} = head;

endmodule

// File: tb/tb_rom_pixel_streamer.sv
// Directed bench: a 4x4 instance for stream/backpressure/reset scenarios and a
// default 256x256 instance for full-frame coordinate coverage.
module tb_rom_pixel_streamer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // 4x4 instance, ROM[i] = i
  logic       start = 1'b0;
  logic       m_ready = 1'b0;
  logic       busy, done, rom_en, m_valid, m_sof, m_eol, m_eof;
  logic [3:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic [7:0] m_data;
  logic [1:0] m_x, m_y;

  rom_pixel_streamer #(
    .WIDTH(4), .HEIGHT(4), .PIXEL_W(8), .ADDR_W(4), .X_W(2), .Y_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_x(m_x), .m_y(m_y),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  always @(posedge clk) if (rom_en) rom_data <= {4'b0000, rom_addr};

  // 256x256 instance, ROM[i] = i[7:0]
  logic        b_start = 1'b0;
  logic        b_ready = 1'b1;
  logic        b_busy, b_done, b_rom_en, b_valid, b_sof, b_eol, b_eof;
  logic [15:0] b_addr;
  logic [7:0]  b_rom_data = '0;
  logic [7:0]  b_data;
  logic [7:0]  b_x, b_y;

  rom_pixel_streamer big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
    .rom_en(b_rom_en), .rom_addr(b_addr), .rom_data(b_rom_data),
    .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data), .m_x(b_x), .m_y(b_y),
    .m_sof(b_sof), .m_eol(b_eol), .m_eof(b_eof)
  );

  always @(posedge clk) if (b_rom_en) b_rom_data <= b_addr[7:0];

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, rom_en, m_valid, m_sof, m_eol, m_eof} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {busy, done, rom_en, m_valid, m_sof, m_eol, m_eof});
    end
    checks++;
    if ({rom_addr, m_data, m_x, m_y} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values got addr=%0d data=%0d x=%0d y=%0d want 0",
               rom_addr, m_data, m_x, m_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // mode 0: ready=1, 1: ready pattern 1,0,0,1, 2: 20-cycle stall, 3: start re-pulsed mid-frame
  task automatic test_stream(input int mode);
    int   cyc = 0, beat = 0, issues = 0, pops = 0, done_cnt = 0, last_cyc = 1000;
    bit   pv, prev_stall = 0;
    logic [7:0] p_data = '0;
    logic [1:0] p_x = '0, p_y = '0;
    bit   pat [4] = '{1, 0, 0, 1};
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b1;
    while (cyc < 300 && !(beat == 16 && cyc > last_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      start = (mode == 3 && (cyc == 6 || cyc == 12)) ? 1'b1 : 1'b0;
      case (mode)
        1:       m_ready = pat[(cyc - 1) % 4];
        2:       m_ready = !(cyc >= 3 && cyc <= 22);
        default: m_ready = 1'b1;
      endcase
      #1;
      pv = m_valid && m_ready;
      if (mode == 0) begin
        checks++;
        if (m_valid !== (cyc >= 3 && cyc <= 18)) begin
          errors++;
          $display("FAIL latency_valid cyc=%0d got %b want %b", cyc, m_valid, (cyc >= 3 && cyc <= 18));
        end
        if (cyc == 1) begin
          checks++;
          if (!(busy === 1'b1 && rom_en === 1'b1 && rom_addr === 4'd0)) begin
            errors++;
            $display("FAIL first_issue got busy=%b rom_en=%b addr=%0d want 1 1 0", busy, rom_en, rom_addr);
          end
        end
      end
      if (mode == 2 && cyc >= 3 && cyc <= 22) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'd0) begin
          errors++;
          $display("FAIL stall_hold cyc=%0d got valid=%b data=%0d want 1 0", cyc, m_valid, m_data);
        end
      end
      if (prev_stall) begin
        checks++;
        if (m_data !== p_data || m_x !== p_x || m_y !== p_y || m_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_stable got %0d/%0d/%0d want %0d/%0d/%0d",
                   m_data, m_x, m_y, p_data, p_x, p_y);
        end
      end
      if (rom_en) begin
        checks++;
        if (issues - pops + 1 - int'(pv) > 2 || rom_addr !== 4'(issues)) begin
          errors++;
          $display("FAIL issue_rule got addr=%0d outstanding=%0d want addr=%0d outstanding<=2",
                   rom_addr, issues - pops + 1 - int'(pv), issues);
        end
        issues++;
      end
      if (mode == 2 && cyc == 22) begin
        checks++;
        if (issues > 2) begin
          errors++;
          $display("FAIL stall_reads got %0d want <=2", issues);
        end
      end
      if (pv) begin
        checks++;
        if (m_data !== 8'(beat) || m_x !== 2'(beat % 4) || m_y !== 2'(beat / 4) ||
            m_sof !== (beat == 0) || m_eol !== (beat % 4 == 3) || m_eof !== (beat == 15)) begin
          errors++;
          $display("FAIL beat%0d got d=%0d x=%0d y=%0d sof=%b eol=%b eof=%b want d=%0d x=%0d y=%0d",
                   beat, m_data, m_x, m_y, m_sof, m_eol, m_eof, beat, beat % 4, beat / 4);
        end
        if (beat == 15) last_cyc = cyc;
        beat++;
        pops++;
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (cyc != last_cyc + 1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_timing got cyc=%0d busy=%b want cyc=%0d busy=0", cyc, busy, last_cyc + 1);
        end
      end
      prev_stall = m_valid && !m_ready;
      p_data = m_data;
      p_x = m_x;
      p_y = m_y;
    end
    start = 1'b0;
    checks++;
    if (beat != 16 || done_cnt != 1) begin
      errors++;
      $display("FAIL frame_total mode=%0d got beats=%0d done=%0d want 16 1", mode, beat, done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0, beat = 0;
    @(negedge clk);
    start = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (beat < 6 && cyc < 50) begin
      #1;
      if (m_valid && m_ready) beat++;
      if (beat < 6) @(negedge clk);
      cyc++;
    end
    checks++;
    if (beat != 6) begin
      errors++;
      $display("FAIL rst_mid_reach got beats=%0d want 6", beat);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, rom_en, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got %b want 0000", {m_valid, rom_en, busy, done});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle got done=%b busy=%b valid=%b want 0 0 0", done, busy, m_valid);
      end
    end
    test_stream(0);
  endtask

  task automatic test_coords();
    int cyc = 0, beat = 0, done_cnt = 0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    while (cyc < 70000 && !(beat == 65536 && done_cnt > 0)) begin
      #1;
      if (b_done) done_cnt++;
      if (b_valid && b_ready) begin
        if (beat == 0 || beat == 255 || beat == 256 || beat == 65535) begin
          checks++;
          if (b_data !== 8'(beat) || b_x !== 8'(beat % 256) || b_y !== 8'(beat / 256) ||
              b_sof !== (beat == 0) || b_eol !== (beat % 256 == 255) || b_eof !== (beat == 65535)) begin
            errors++;
            $display("FAIL coord_beat%0d got d=%0d x=%0d y=%0d sof=%b eol=%b eof=%b want x=%0d y=%0d",
                     beat, b_data, b_x, b_y, b_sof, b_eol, b_eof, beat % 256, beat / 256);
          end
        end
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (beat != 65536 || done_cnt != 1) begin
      errors++;
      $display("FAIL coord_total got beats=%0d done=%0d want 65536 1", beat, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream(0);
    test_stream(1);
    test_stream(2);
    test_stream(3);
    test_reset_mid_frame();
    test_coords();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
